tcu_drl_step_sched: RTL and testbench

- Sequencer for the TCU DRL dot-product datapath (exponent/bias stage through accumulate).
- Accepts one tile-step request: format, K-step count, lane mask and initial C.
- Pulls one A/B operand beat per step, issues it to the datapath, and feeds each returned accumulator back as the next step's C.
- Returns the final accumulator to the requester. Sits between the TCU operand collector and the FEDP pipeline.

---
 rtl/tcu_drl_step_sched.sv | 244 ++++++++++++++++++++++++
 tb/tb_tcu_drl_step_sched.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcu_drl_step_sched.sv
// Purpose : sequences one TCU DRL tile-step request through the dot-product datapath, chaining each result back as the next C.
// Latency : per K-step FETCH(>=1) + ISSUE(1) + WAIT(>=1) cycles; zero-step or bad-format requests respond 1 cycle after accept.
// Backpres: req_ready only in IDLE, op_ready only in FETCH, response held stable until rsp_ready; optional perf counters under TCU_DRL_SCHED_PERF_EN.
module tcu_drl_step_sched #(
    parameter int N      = 2,
    parameter int MASK_W = 8,
    parameter int STEP_W = 8,
    parameter int DP_LAT = 4
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                req_valid,
    output logic                req_ready,
    input  logic [2:0]          req_fmtf,
    input  logic [STEP_W-1:0]   req_steps,
    input  logic [MASK_W-1:0]   req_mask,
    input  logic [31:0]         req_c,

    input  logic                op_valid,
    output logic                op_ready,
    input  logic [N*32-1:0]     op_a,
    input  logic [N*32-1:0]     op_b,

    output logic                dp_valid,
    output logic [2:0]          dp_fmtf,
    output logic [MASK_W-1:0]   dp_mask,
    output logic [N*32-1:0]     dp_a,
    output logic [N*32-1:0]     dp_b,
    output logic [31:0]         dp_c,
    input  logic                dp_res_valid,
    input  logic [31:0]         dp_res,

    output logic                rsp_valid,
    output logic [31:0]         rsp_data,
    output logic                rsp_err,
    input  logic                rsp_ready,

    output logic                busy
`ifdef TCU_DRL_SCHED_PERF_EN
    ,
    output logic [31:0]         perf_steps,
    output logic [31:0]         perf_op_stall,
    output logic [31:0]         perf_lat_stall
`endif
);

    // Format IDs understood by the FEDP datapath; everything else is rejected.
    localparam logic [2:0] TCU_TF32_ID = 3'd0;
    localparam logic [2:0] TCU_FP16_ID = 3'd1;
    localparam logic [2:0] TCU_BF16_ID = 3'd2;
    localparam logic [2:0] TCU_FP8_ID  = 3'd3;
    localparam logic [2:0] TCU_BF8_ID  = 3'd4;

    localparam logic [STEP_W-1:0] STEP_ONE  = {{(STEP_W-1){1'b0}}, 1'b1};
    localparam logic [STEP_W-1:0] STEP_ZERO = '0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [STEP_W-1:0]  rem_cnt;
    logic [31:0]        acc;
    logic               fmt_ok;

    // A result with latency below one cycle is meaningless for this chain.
    if (DP_LAT < 1) begin : g_lat_chk
        $error("DP_LAT must be at least 1");
    end

    // Decode whether the incoming format is one of the five supported IDs.
    always_comb begin
        fmt_ok = 1'b0;
        case (req_fmtf)
            TCU_TF32_ID,
            TCU_FP16_ID,
            TCU_BF16_ID,
            TCU_FP8_ID,
            TCU_BF8_ID:  fmt_ok = 1'b1;
            default:     fmt_ok = 1'b0;
        endcase
    end

    // State register; reset forces IDLE regardless of anything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. WAIT never advances without a result, which keeps
    // the accumulate chain strictly serial.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (!fmt_ok) begin
                        state_nxt = S_RESP;
                    end else if (req_steps == STEP_ZERO) begin
                        state_nxt = S_RESP;
                    end else begin
                        state_nxt = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (op_valid) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (dp_res_valid) begin
                    state_nxt = (rem_cnt == STEP_ZERO) ? S_RESP : S_FETCH;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Handshake/status outputs decoded from state; req_ready stays low while
    // reset is held so it first rises the cycle after reset drops.
    always_comb begin
        req_ready = (state == S_IDLE) && !reset;
        op_ready  = (state == S_FETCH);
        dp_valid  = (state == S_ISSUE);
        rsp_valid = (state == S_RESP);
        busy      = (state != S_IDLE);
    end

    // Request context, operand beat and accumulator registers. Results are
    // only taken in WAIT, so stray or zero-latency results are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            dp_fmtf <= '0;
            dp_mask <= '0;
            rem_cnt <= '0;
            acc     <= '0;
            dp_a    <= '0;
            dp_b    <= '0;
            rsp_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        dp_fmtf <= req_fmtf;
                        dp_mask <= req_mask;
                        rem_cnt <= req_steps;
                        acc     <= req_c;
                        rsp_err <= !fmt_ok;
                    end
                end
                S_FETCH: begin
                    if (op_valid) begin
                        dp_a <= op_a;
                        dp_b <= op_b;
                    end
                end
                S_ISSUE: begin
                    if (rem_cnt != STEP_ZERO) begin
                        rem_cnt <= rem_cnt - STEP_ONE;
                    end
                end
                S_WAIT: begin
                    if (dp_res_valid) begin
                        acc <= dp_res;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_err <= 1'b0;
                    end
                end
                default: begin
                    rem_cnt <= rem_cnt;
                end
            endcase
        end
    end

    // The accumulator doubles as the datapath C operand and the response data.
    always_comb begin
        dp_c     = acc;
        rsp_data = acc;
    end

`ifdef TCU_DRL_SCHED_PERF_EN
    localparam logic [15:0] LAT_THR = 16'(DP_LAT);

    logic [15:0] wait_cnt;

    // Count cycles spent in the current WAIT; saturates so long stalls stay counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state == S_ISSUE) begin
            wait_cnt <= '0;
        end else if ((state == S_WAIT) && (wait_cnt != 16'hFFFF)) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    // Saturating performance counters, kept across requests until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_steps     <= '0;
            perf_op_stall  <= '0;
            perf_lat_stall <= '0;
        end else begin
            if ((state == S_ISSUE) && (perf_steps != 32'hFFFF_FFFF)) begin
                perf_steps <= perf_steps + 32'd1;
            end
            if ((state == S_FETCH) && !op_valid && (perf_op_stall != 32'hFFFF_FFFF)) begin
                perf_op_stall <= perf_op_stall + 32'd1;
            end
            // wait_cnt holds the number of earlier WAIT cycles for this step.
            if ((state == S_WAIT) && (wait_cnt >= LAT_THR) &&
                (perf_lat_stall != 32'hFFFF_FFFF)) begin
                perf_lat_stall <= perf_lat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tcu_drl_step_sched.sv
// Purpose : directed bench for tcu_drl_step_sched with a small latency-programmable datapath model.
// Latency : model returns f(C) lat_cfg cycles after each issue pulse.
// Backpres: bench controls op_valid and rsp_ready directly to exercise stalls.
module tb_tcu_drl_step_sched;

    localparam int N      = 2;
    localparam int MASK_W = 8;
    localparam int STEP_W = 8;
    localparam int DP_LAT = 4;

    logic                clk;
    logic                reset;
    logic                req_valid;
    logic                req_ready;
    logic [2:0]          req_fmtf;
    logic [STEP_W-1:0]   req_steps;
    logic [MASK_W-1:0]   req_mask;
    logic [31:0]         req_c;
    logic                op_valid;
    logic                op_ready;
    logic [N*32-1:0]     op_a;
    logic [N*32-1:0]     op_b;
    logic                dp_valid;
    logic [2:0]          dp_fmtf;
    logic [MASK_W-1:0]   dp_mask;
    logic [N*32-1:0]     dp_a;
    logic [N*32-1:0]     dp_b;
    logic [31:0]         dp_c;
    logic                dp_res_valid;
    logic [31:0]         dp_res;
    logic                rsp_valid;
    logic [31:0]         rsp_data;
    logic                rsp_err;
    logic                rsp_ready;
    logic                busy;
`ifdef TCU_DRL_SCHED_PERF_EN
    logic [31:0]         perf_steps;
    logic [31:0]         perf_op_stall;
    logic [31:0]         perf_lat_stall;
`endif

    tcu_drl_step_sched #(
        .N      (N),
        .MASK_W (MASK_W),
        .STEP_W (STEP_W),
        .DP_LAT (DP_LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_fmtf     (req_fmtf),
        .req_steps    (req_steps),
        .req_mask     (req_mask),
        .req_c        (req_c),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op_a         (op_a),
        .op_b         (op_b),
        .dp_valid     (dp_valid),
        .dp_fmtf      (dp_fmtf),
        .dp_mask      (dp_mask),
        .dp_a         (dp_a),
        .dp_b         (dp_b),
        .dp_c         (dp_c),
        .dp_res_valid (dp_res_valid),
        .dp_res       (dp_res),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .rsp_ready    (rsp_ready),
        .busy         (busy)
`ifdef TCU_DRL_SCHED_PERF_EN
        ,
        .perf_steps     (perf_steps),
        .perf_op_stall  (perf_op_stall),
        .perf_lat_stall (perf_lat_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Issue-pulse log and op_ready cycle count, written only by the monitor.
    logic [31:0] dpc_log [0:63];
    int          dp_cnt     = 0;
    int          op_rdy_cnt = 0;

    // Datapath model state, written only by the model process.
    int          lat_cfg   = 4;
    int          spur_req  = 0;
    int          spur_done = 0;
    int          m_cnt     = 0;
    logic [31:0] m_pend    = '0;

    // Hand-tabulated fp32 "C + 1.0" for the values the tests use.
    function automatic logic [31:0] f_plus1(input logic [31:0] c);
        case (c)
            32'h0000_0000: return 32'h3F80_0000;
            32'h3F80_0000: return 32'h4000_0000;
            32'h4000_0000: return 32'h4040_0000;
            32'h4040_0000: return 32'h4080_0000;
            32'h4080_0000: return 32'h40A0_0000;
            default:       return c + 32'd1;
        endcase
    endfunction

    // Monitor: record dp_c on every issue pulse, count op_ready cycles.
    always @(negedge clk) begin
        if (dp_valid) begin
            if (dp_cnt < 64) dpc_log[dp_cnt] <= dp_c;
            dp_cnt <= dp_cnt + 1;
        end
        if (op_ready) op_rdy_cnt <= op_rdy_cnt + 1;
    end

    // Datapath model: flushed by reset, returns f(C) lat_cfg cycles after issue,
    // and can inject one-cycle spurious results on request.
    initial begin
        dp_res_valid = 1'b0;
        dp_res       = '0;
        forever begin
            @(posedge clk);
            #2;
            dp_res_valid = 1'b0;
            dp_res       = '0;
            if (reset) begin
                m_cnt = 0;
            end else begin
                if (m_cnt > 0) begin
                    m_cnt = m_cnt - 1;
                    if (m_cnt == 0) begin
                        dp_res_valid = 1'b1;
                        dp_res       = m_pend;
                    end
                end
                if (dp_valid) begin
                    m_cnt  = lat_cfg;
                    m_pend = f_plus1(dp_c);
                end
                if (spur_done != spur_req) begin
                    spur_done    = spur_done + 1;
                    dp_res_valid = 1'b1;
                    dp_res       = 32'hDEAD_BEEF;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_req(input logic [2:0] f, input logic [7:0] s,
                            input logic [7:0] m, input logic [31:0] c);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_fmtf  = f;
        req_steps = s;
        req_mask  = m;
        req_c     = c;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        checks++;
        if ({busy, op_ready, dp_valid, rsp_valid, rsp_err} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 00000", {busy, op_ready, dp_valid, rsp_valid, rsp_err});
        end
        checks++;
        if (dp_c !== 32'h0 || rsp_data !== 32'h0 || dp_a !== '0 || dp_fmtf !== 3'd0) begin
            errors++; $display("FAIL reset_data: dp_c %h rsp_data %h dp_a %h dp_fmtf %0d want all 0", dp_c, rsp_data, dp_a, dp_fmtf);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_fp16_chain();
        int base;
        bit ok;
        base     = dp_cnt;
        lat_cfg  = 4;
        op_valid = 1'b1;
        op_a     = 64'h1111_2222_3333_4444;
        op_b     = 64'h5555_6666_7777_8888;
        send_req(3'd1, 8'd3, 8'hFF, 32'h3F80_0000);
        wait_rsp(200, ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL chain_timeout: rsp_valid %b want 1", rsp_valid); end
        checks++;
        if (rsp_data !== 32'h4080_0000 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL chain_rsp: data %h err %b want 40800000 0", rsp_data, rsp_err);
        end
        checks++;
        if (dp_cnt - base !== 3) begin errors++; $display("FAIL chain_issues: got %0d want 3", dp_cnt - base); end
        checks++;
        if (dpc_log[base] !== 32'h3F80_0000 || dpc_log[base+1] !== 32'h4000_0000 || dpc_log[base+2] !== 32'h4040_0000) begin
            errors++; $display("FAIL chain_dp_c: got %h %h %h want 3f800000 40000000 40400000", dpc_log[base], dpc_log[base+1], dpc_log[base+2]);
        end
        checks++;
        if (dp_fmtf !== 3'd1 || dp_mask !== 8'hFF || dp_a !== 64'h1111_2222_3333_4444 || dp_b !== 64'h5555_6666_7777_8888) begin
            errors++; $display("FAIL chain_dp_regs: fmtf %0d mask %h a %h b %h", dp_fmtf, dp_mask, dp_a, dp_b);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL chain_idle: busy %b rsp_valid %b want 0 0", busy, rsp_valid); end
    endtask

    task automatic test_zero_steps();
        int base;
        base = dp_cnt;
        send_req(3'd1, 8'd0, 8'hFF, 32'h4049_0FDB);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h4049_0FDB || rsp_err !== 1'b0) begin
            errors++; $display("FAIL zero_rsp: valid %b data %h err %b want 1 40490fdb 0", rsp_valid, rsp_data, rsp_err);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || dp_cnt - base !== 0) begin
            errors++; $display("FAIL zero_after: rsp_valid %b issues %0d want 0 0", rsp_valid, dp_cnt - base);
        end
    endtask

    task automatic test_bad_fmt();
        int  base_dp;
        int  base_op;
        bit  ok;
        base_dp = dp_cnt;
        base_op = op_rdy_cnt;
        send_req(3'b111, 8'd5, 8'h3C, 32'h1234_5678);
        wait_rsp(20, ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL badfmt_timeout: rsp_valid %b want 1", rsp_valid); end
        checks++;
        if (rsp_err !== 1'b1 || rsp_data !== 32'h1234_5678) begin
            errors++; $display("FAIL badfmt_rsp: err %b data %h want 1 12345678", rsp_err, rsp_data);
        end
        checks++;
        if (dp_cnt - base_dp !== 0 || op_rdy_cnt - base_op !== 0) begin
            errors++; $display("FAIL badfmt_no_issue: issues %0d op_ready cycles %0d want 0 0", dp_cnt - base_dp, op_rdy_cnt - base_op);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rsp_err !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL badfmt_clear: err %b valid %b want 0 0", rsp_err, rsp_valid);
        end
    endtask

    task automatic test_stalls();
        int          base;
        bit          ok;
        logic [31:0] held;
        base      = dp_cnt;
        lat_cfg   = 1;
        op_valid  = 1'b0;
        rsp_ready = 1'b0;
        op_a      = 64'hA5A5_A5A5_0F0F_0F0F;
        op_b      = 64'h5A5A_5A5A_F0F0_F0F0;
        send_req(3'd4, 8'd2, 8'h0F, 32'h4000_0000);
        repeat (6) @(posedge clk);
        checks++;
        if (dp_cnt - base !== 0 || op_ready !== 1'b1) begin
            errors++; $display("FAIL stall_no_issue: issues %0d op_ready %b want 0 1", dp_cnt - base, op_ready);
        end
        #1;
        op_valid = 1'b1;
        wait_rsp(100, ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL stall_timeout: rsp_valid %b want 1", rsp_valid); end
        held = rsp_data;
        checks++;
        if (held !== 32'h4080_0000) begin errors++; $display("FAIL stall_rsp: data %h want 40800000", held); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'h4080_0000) begin
                errors++; $display("FAIL stall_rsp_hold: cycle %0d valid %b data %h want 1 40800000", i, rsp_valid, rsp_data);
            end
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL stall_rsp_last: valid %b want 1", rsp_valid); end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL stall_done: valid %b busy %b want 0 0", rsp_valid, busy); end
        checks++;
        if (dp_cnt - base !== 2 || dpc_log[base] !== 32'h4000_0000 || dpc_log[base+1] !== 32'h4040_0000) begin
            errors++; $display("FAIL stall_dp_c: issues %0d c0 %h c1 %h want 2 40000000 40400000", dp_cnt - base, dpc_log[base], dpc_log[base+1]);
        end
        checks++;
        if (dp_fmtf !== 3'd4 || dp_mask !== 8'h0F || dp_a !== 64'hA5A5_A5A5_0F0F_0F0F) begin
            errors++; $display("FAIL stall_dp_regs: fmtf %0d mask %h a %h want 4 0f a5a5a5a50f0f0f0f", dp_fmtf, dp_mask, dp_a);
        end
`ifdef TCU_DRL_SCHED_PERF_EN
        checks++;
        if (perf_op_stall !== 32'd6 || perf_steps !== 32'd5) begin
            errors++; $display("FAIL perf_stall: op_stall %0d steps %0d want 6 5", perf_op_stall, perf_steps);
        end
`endif
    endtask

    task automatic test_spurious();
        int base;
        bit ok;
        lat_cfg  = 6;
        op_valid = 1'b0;
        @(posedge clk);
        #1;
        spur_req = spur_req + 1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (dp_c !== 32'h4080_0000 || busy !== 1'b0) begin
            errors++; $display("FAIL spur_idle: dp_c %h busy %b want 40800000 0", dp_c, busy);
        end
        base = dp_cnt;
        send_req(3'd1, 8'd2, 8'hFF, 32'h3F80_0000);
        spur_req = spur_req + 1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (dp_c !== 32'h3F80_0000 || op_ready !== 1'b1) begin
            errors++; $display("FAIL spur_fetch: dp_c %h op_ready %b want 3f800000 1", dp_c, op_ready);
        end
        @(posedge clk);
        #1;
        op_valid = 1'b1;
        wait_rsp(200, ok);
        checks++;
        if (ok !== 1'b1 || rsp_data !== 32'h4040_0000) begin
            errors++; $display("FAIL spur_rsp: ok %b data %h want 1 40400000", ok, rsp_data);
        end
        checks++;
        if (dp_cnt - base !== 2 || dpc_log[base] !== 32'h3F80_0000 || dpc_log[base+1] !== 32'h4000_0000) begin
            errors++; $display("FAIL spur_dp_c: issues %0d c0 %h c1 %h want 2 3f800000 40000000", dp_cnt - base, dpc_log[base], dpc_log[base+1]);
        end
`ifdef TCU_DRL_SCHED_PERF_EN
        checks++;
        if (perf_lat_stall !== 32'd4 || perf_steps !== 32'd7 || perf_op_stall !== 32'd8) begin
            errors++; $display("FAIL perf_lat: lat_stall %0d steps %0d op_stall %0d want 4 7 8", perf_lat_stall, perf_steps, perf_op_stall);
        end
`endif
        @(posedge clk);
    endtask

    task automatic test_reset_mid();
        int base;
        int seen;
        bit found;
        bit ok;
        lat_cfg  = 4;
        op_valid = 1'b1;
        seen     = 0;
        found    = 1'b0;
        send_req(3'd1, 8'd4, 8'hFF, 32'h0000_0000);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dp_valid) seen++;
            if (seen == 2) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (found !== 1'b1) begin errors++; $display("FAIL mid_timeout: issues seen %0d want 2", seen); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, dp_valid, rsp_valid, req_ready} !== 4'b0001) begin
            errors++; $display("FAIL mid_reset_ctrl: busy/dp_valid/rsp_valid/req_ready %b want 0001", {busy, dp_valid, rsp_valid, req_ready});
        end
        checks++;
        if (dp_c !== 32'h0 || rsp_data !== 32'h0) begin
            errors++; $display("FAIL mid_reset_data: dp_c %h rsp_data %h want 0 0", dp_c, rsp_data);
        end
        base = dp_cnt;
        send_req(3'd1, 8'd1, 8'hFF, 32'h4040_0000);
        wait_rsp(100, ok);
        checks++;
        if (ok !== 1'b1 || rsp_data !== 32'h4080_0000 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL mid_new_req: ok %b data %h err %b want 1 40800000 0", ok, rsp_data, rsp_err);
        end
        checks++;
        if (dp_cnt - base !== 1 || dpc_log[base] !== 32'h4040_0000) begin
            errors++; $display("FAIL mid_new_issue: issues %0d c0 %h want 1 40400000", dp_cnt - base, dpc_log[base]);
        end
        @(posedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_fmtf  = '0;
        req_steps = '0;
        req_mask  = '0;
        req_c     = '0;
        op_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        rsp_ready = 1'b1;

        test_reset();
        test_fp16_chain();
        test_zero_steps();
        test_bad_fmt();
        test_stalls();
        test_spurious();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
